// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sevenseg_pkg;

   typedef logic [6:0] digit_code_t;

   // Bit 6 set tells the downstream decoder to blank the digit.
   localparam digit_code_t BLANK_CODE = 7'b100_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } scan_state_t;

endpackage

// File: rtl/scan_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module scan_timer #(
   parameter int WIDTH = 17
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             done
);

   logic [WIDTH-1:0] count;

   // Load takes priority; otherwise count down and park at zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - WIDTH'(1);
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// Holds one code per digit and walks the digits through ON and GAP slots.
module sevenseg_scan_ctrl
   import sevenseg_pkg::*;
#(
   parameter int DIGITS     = 8,
   parameter int ON_CYCLES  = 100000,
   parameter int GAP_CYCLES = 1000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [DIGITS-1:0]         digit_mask,
   input  logic                      wr_en,
   input  logic [$clog2(DIGITS)-1:0] wr_idx,
   input  logic [6:0]                wr_data,
   output logic [6:0]                seg_code,
   output logic [DIGITS-1:0]         an_n,
   output logic                      frame_tick
);

   localparam int IDX_W      = $clog2(DIGITS);
   localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
   localparam int TW         = $clog2(MAX_CYCLES + 1);

   localparam logic [TW-1:0]    ON_LOAD     = TW'(ON_CYCLES - 1);
   localparam logic [TW-1:0]    GAP_LOAD    = TW'(GAP_CYCLES - 1);
   localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DIGITS - 1);
   localparam logic [IDX_W:0]   DIGIT_COUNT = (IDX_W + 1)'(DIGITS);

   digit_code_t       code_regs [DIGITS];
   scan_state_t       state, next_state;
   logic [IDX_W-1:0]  idx, next_idx;
   digit_code_t       latched_code, next_code;
   logic              entering_on;
   logic              timer_load;
   logic [TW-1:0]     timer_value;
   logic              timer_done;
   logic [DIGITS-1:0] next_an_n;
   digit_code_t       next_seg;
   logic              next_tick;

   scan_timer #(
      .WIDTH(TW)
   ) u_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (timer_load),
      .load_value(timer_value),
      .done      (timer_done)
   );

   // Code register file; out-of-range indices are dropped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DIGITS; i++) begin
            code_regs[i] <= BLANK_CODE;
         end
      end else if (wr_en && ({1'b0, wr_idx} < DIGIT_COUNT)) begin
         code_regs[wr_idx] <= wr_data;
      end
   end

   // Next state, slot timing and the output values for the coming cycle.
   always_comb begin
      next_state  = state;
      next_idx    = idx;
      timer_load  = 1'b0;
      timer_value = '0;
      entering_on = 1'b0;
      case (state)
         IDLE: begin
            if (en) begin
               next_state  = ON;
               next_idx    = '0;
               timer_load  = 1'b1;
               timer_value = ON_LOAD;
               entering_on = 1'b1;
            end
         end
         ON: begin
            if (!en) begin
               next_state = IDLE;
            end else if (timer_done) begin
               next_state  = GAP;
               timer_load  = 1'b1;
               timer_value = GAP_LOAD;
            end
         end
         GAP: begin
            if (!en) begin
               next_state = IDLE;
            end else if (timer_done) begin
               next_state  = ON;
               next_idx    = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
               timer_load  = 1'b1;
               timer_value = ON_LOAD;
               entering_on = 1'b1;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase

      if (next_state == IDLE) begin
         next_idx = '0;
      end

      // The register file is read before any same-edge write lands, so a
      // write on the latch edge leaves the old code on screen for the slot.
      next_code = entering_on ? code_regs[next_idx] : latched_code;

      next_an_n = '1;
      next_seg  = BLANK_CODE;
      next_tick = 1'b0;
      if (next_state == ON) begin
         if (digit_mask[next_idx]) begin
            next_an_n[next_idx] = 1'b0;
            next_seg            = next_code;
         end
         next_tick = entering_on && (next_idx == '0);
      end
   end

   // State, digit index, per-slot code latch and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         idx          <= '0;
         latched_code <= BLANK_CODE;
         an_n         <= '1;
         seg_code     <= BLANK_CODE;
         frame_tick   <= 1'b0;
      end else begin
         state        <= next_state;
         idx          <= next_idx;
         latched_code <= next_code;
         an_n         <= next_an_n;
         seg_code     <= next_seg;
         frame_tick   <= next_tick;
      end
   end

endmodule

// File: tb/tb_sevenseg_scan_ctrl.sv
// Directed self-checking bench for sevenseg_scan_ctrl with 4 digits,
// 4-cycle ON slots and 1-cycle gaps (20-cycle frame).
module tb_sevenseg_scan_ctrl;

   localparam int DIGITS = 4;
   localparam int ON_C   = 4;
   localparam int GAP_C  = 1;
   localparam int SLOT_C = ON_C + GAP_C;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic [3:0] digit_mask;
   logic       wr_en;
   logic [1:0] wr_idx;
   logic [6:0] wr_data;
   logic [6:0] seg_code;
   logic [3:0] an_n;
   logic       frame_tick;

   int compareCount  = 0;
   int mismatchCount = 0;
   int scanCycle     = 0;

   logic [6:0] modelReg [DIGITS];
   logic [6:0] modelLatched;
   logic [6:0] initCodes [DIGITS];

   sevenseg_scan_ctrl #(
      .DIGITS    (DIGITS),
      .ON_CYCLES (ON_C),
      .GAP_CYCLES(GAP_C)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .digit_mask(digit_mask),
      .wr_en     (wr_en),
      .wr_idx    (wr_idx),
      .wr_data   (wr_data),
      .seg_code  (seg_code),
      .an_n      (an_n),
      .frame_tick(frame_tick)
   );

   // Free-running clock, 10 time-unit period.
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compareCount++;
      if (observed !== expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
      end
   endtask

   // Dark-display check used while idle or in reset.
   task automatic checkDark(input string tag);
      @(negedge clk);
      checkOutput({tag, " an_n"}, 32'(an_n), 32'hF);
      checkOutput({tag, " seg"}, 32'(seg_code), 32'h40);
      checkOutput({tag, " tick"}, 32'(frame_tick), 32'h0);
   endtask

   // One scanning cycle: advance to the negedge, update the reference
   // (latch on slot entry before applying the write committed on that
   // same edge), then compare all three outputs.
   task automatic applyStimulus();
      int slot;
      int pos;
      logic [3:0] expAn;
      logic [6:0] expSeg;
      logic       expTick;
      @(negedge clk);
      slot = (scanCycle / SLOT_C) % DIGITS;
      pos  = scanCycle % SLOT_C;
      if (pos == 0) modelLatched = modelReg[slot];
      if (wr_en) modelReg[wr_idx] = wr_data;
      expAn   = 4'hF;
      expSeg  = 7'h40;
      expTick = 1'b0;
      if (pos < ON_C) begin
         if (digit_mask[slot]) begin
            expAn[slot] = 1'b0;
            expSeg      = modelLatched;
         end
         expTick = (slot == 0) && (pos == 0);
      end
      checkOutput($sformatf("an_n c%0d", scanCycle), 32'(an_n), 32'(expAn));
      checkOutput($sformatf("seg c%0d", scanCycle), 32'(seg_code), 32'(expSeg));
      checkOutput($sformatf("tick c%0d", scanCycle), 32'(frame_tick), 32'(expTick));
      scanCycle++;
   endtask

   initial begin
      initCodes[0] = 7'h03;
      initCodes[1] = 7'h05;
      initCodes[2] = 7'h07;
      initCodes[3] = 7'h09;

      rst_n      = 1'b0;
      en         = 1'b1;
      digit_mask = 4'hF;
      wr_en      = 1'b0;
      wr_idx     = 2'd0;
      wr_data    = 7'h00;

      // Reset held three cycles with enable high.
      for (int i = 0; i < 3; i++) checkDark("reset");
      rst_n = 1'b1;

      // First ON cycle right after release, with the cleared (blank) code.
      @(negedge clk);
      checkOutput("release an_n", 32'(an_n), 32'hE);
      checkOutput("release seg", 32'(seg_code), 32'h40);
      checkOutput("release tick", 32'(frame_tick), 32'h1);
      en = 1'b0;
      checkDark("disable");

      // Load codes while idle.
      for (int i = 0; i < DIGITS; i++) begin
         wr_en   = 1'b1;
         wr_idx  = 2'(i);
         wr_data = initCodes[i];
         checkDark("idle write");
         modelReg[i] = initCodes[i];
      end
      wr_en = 1'b0;

      // Frame 1: basic scan, plus a mid-slot write to digit 0 and a write
      // to digit 1 that lands on its latch edge.
      en        = 1'b1;
      scanCycle = 0;
      for (int c = 0; c < 20; c++) begin
         applyStimulus();
         if (c == 1) begin
            wr_en = 1'b1; wr_idx = 2'd0; wr_data = 7'h0F;
         end else if (c == 4) begin
            wr_en = 1'b1; wr_idx = 2'd1; wr_data = 7'h11;
         end else begin
            wr_en = 1'b0;
         end
      end

      // Frame 2: digit 2 masked; frame timing unchanged.
      digit_mask = 4'b1011;
      for (int c = 0; c < 20; c++) applyStimulus();
      digit_mask = 4'hF;

      // Frame 3: drop enable in digit 2's second ON cycle.
      for (int c = 0; c < 12; c++) applyStimulus();
      en = 1'b0;
      for (int i = 0; i < 3; i++) checkDark("en drop");

      // Re-enable restarts at digit 0; reset during digit 1's gap.
      en        = 1'b1;
      scanCycle = 0;
      for (int c = 0; c < 10; c++) applyStimulus();
      rst_n = 1'b0;
      checkDark("mid reset");
      rst_n = 1'b1;
      for (int i = 0; i < DIGITS; i++) modelReg[i] = 7'h40;
      scanCycle = 0;
      for (int c = 0; c < 20; c++) applyStimulus();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/sevenseg_scan_ctrl.md
# sevenseg_scan_ctrl

Time-multiplexing scan controller for a multi-digit common-anode seven-segment display. It holds one 7-bit display code per digit and sequences them, one digit at a time, onto the single shared `seven_seg_n` decoder. It drives the active-low digit anodes and inserts a blanking gap between digits to suppress ghosting. It sits between the system's register-write logic and the `seven_seg_n` decoder / board anode pins.

## Interface

Parameters:
- `DIGITS`, 8: number of digits scanned (2..16).
- `ON_CYCLES`, 100000: clock cycles each digit's anode is driven (≥1).
- `GAP_CYCLES`, 1000: clock cycles with all anodes off between digits (≥1).

Ports:
- `clk`  in  1  system clock. One clock; reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `en`  in  1  scan enable. When 0, the display is dark and the controller idles.
- `digit_mask`  in  DIGITS  per-digit enable. A 0 keeps that digit's anode off during its slot.
- `wr_en`  in  1  write strobe for the code register file.
- `wr_idx`  in  $clog2(DIGITS)  digit to write. Values ≥ DIGITS are ignored.
- `wr_data`  in  7  display code, in `seven_seg_n` `data` format.
- `seg_code`  out  7  registered code to the `seven_seg_n` `data` input.
- `an_n`  out  DIGITS  registered active-low anode enables; at most one bit low.
- `frame_tick`  out  1  one-cycle pulse at the start of each digit-0 slot.

## Operation

- The register file holds `DIGITS` x 7-bit codes. Reset value of every entry is `BLANK_CODE` (7'b100_0000, bit 6 = blank).
- A write with `wr_en`=1 updates the entry on the next clock edge. Writes are accepted in every state.
- The FSM has three states: IDLE, ON and GAP. There is one digit index `idx` and one down-counter sized for max(ON_CYCLES, GAP_CYCLES).
  - **IDLE:** `an_n` is all 1 and `seg_code` is `BLANK_CODE`. If `en`=1, the next state is ON with `idx`=0.
  - **ON:** lasts ON_CYCLES cycles.
    - `seg_code` = the code latched on entry.
    - `an_n[idx]` = 0 only if `digit_mask[idx]`=1. Other anode bits are 1.
    - On expiry the next state is GAP.
  - **GAP:** lasts GAP_CYCLES cycles.
    - `an_n` is all 1 and `seg_code` is `BLANK_CODE`.
    - On expiry the next state is ON with `idx` = (idx+1) mod DIGITS, wrapping from DIGITS-1 to 0.
- In a masked slot (`digit_mask[idx]`=0), `seg_code` = `BLANK_CODE` and the slot time is still consumed. This keeps frame timing and brightness uniform.
- `en`=0 in any state sends the FSM to IDLE on the next edge. Outputs go dark on that same edge. The next enable restarts at digit 0.
- Reset mid-operation returns the FSM to IDLE, blanks all outputs and clears the register file.

## Timing

- All outputs are registered.
- Reset values: `an_n` = all 1, `seg_code` = `BLANK_CODE`, `frame_tick` = 0, state = IDLE, `idx` = 0.
- Enable latency: `en` rises before edge E. At E the state becomes ON. `an_n[0]` goes low and `seg_code` = reg[0] in the cycle after E. `frame_tick` = 1 in that same cycle.
- The code is latched once per slot, on the GAP→ON (or IDLE→ON) edge. A write to the currently displayed digit becomes visible at that digit's next slot, never mid-slot.
- If a write to digit k coincides with the latch edge for digit k, the slot shows the old value.
- The digit period is ON_CYCLES + GAP_CYCLES. The frame period is DIGITS × (ON_CYCLES + GAP_CYCLES).
- `frame_tick` pulses once per frame, in the first ON cycle of digit 0.
- `digit_mask` is sampled every cycle. A change takes effect on `an_n` on the next edge, even mid-slot.

## Structure

- Package `sevenseg_pkg` contains:
  - `BLANK_CODE`;
  - the state enum `scan_state_t` (IDLE, ON, GAP);
  - a `digit_code_t` typedef (logic [6:0]).
- Sub-module `scan_timer`: loadable down-counter with a `done` flag, reused for the ON and GAP durations.
- The `seven_seg_n` decoder is instantiated by the parent, not inside this block.

## Test plan

- **Reset:** hold `rst_n`=0 for 3 cycles with `en`=1, then release.
  - During reset: `an_n`=all 1, `seg_code`=7'h40, `frame_tick`=0.
  - The first ON cycle follows one cycle after release.
- **Basic scan:** DIGITS=4, ON=4, GAP=1, mask=4'hF, codes 3,5,7,9.
  - `an_n` sequence: 1110 (4 cycles) / 1111 (1) / 1101 (4) / 1111 (1) / 1011 / 1111 / 0111 / 1111 / 1110.
  - `seg_code` = 3,5,7,9 in the matching ON slots.
  - `frame_tick` every 20 cycles.
- **Mask:** mask=4'b1011.
  - Digit-2 slot: `an_n`=1111 and `seg_code`=7'h40 for 4 cycles.
  - Frame period stays 20 cycles.
- **Write during slot:** write 4'hF to digit 0 in the 2nd cycle of digit 0's ON.
  - `seg_code` stays 3 for the rest of the slot and shows 7'h0F in the next frame's digit-0 slot.
  - A write on the latch edge shows the old value.
- **Enable drop:** deassert `en` in the 2nd ON cycle of digit 2.
  - Next cycle: `an_n`=1111 and `seg_code`=7'h40.
  - On re-enable, the scan restarts at digit 0 with `frame_tick`=1.
- **Reset mid-frame:** assert `rst_n`=0 for 1 cycle during a digit-1 GAP.
  - All codes read back as blank.
  - The scan restarts at digit 0.
